// File: rtl/alu_result_buffer.sv
// Captures ALU results a fixed two edges after issue into an accumulator and a
// 4-entry first-word-fall-through FIFO, with credit-based issue throttling.
module alu_result_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_enable,
  input  logic [3:0]  alu_control,
  input  logic [31:0] c_bus,
  output logic        issue_ready,
  output logic [31:0] ac,
  output logic        z_flag,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic [2:0]  count,
  output logic        overflow_err
);
  localparam int STAGES = 2;
  localparam int DEPTH  = 4;

  logic [STAGES:1]      r_vld_pipe;
  logic [STAGES:1][3:0] r_op_pipe;
  logic [DEPTH-1:0][31:0] r_mem;
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;
  logic [31:0] r_ac;
  logic        r_z, r_ovf;

  logic        w_push, w_pop, w_accept;
  logic [3:0]  w_credit;
  logic        w_unused_op;

  assign w_pop    = out_valid & out_ready;
  assign w_push   = r_vld_pipe[STAGES];
  // Every in-flight issue already owns a FIFO slot, so a push can never hit a full FIFO.
  assign w_credit = {1'b0, r_count} + {3'b0, r_vld_pipe[1]} + {3'b0, r_vld_pipe[2]}
                  - {3'b0, w_pop};
  assign issue_ready = (w_credit < 4'd4);
  assign w_accept    = alu_enable & issue_ready;

  // Opcode travels with the result for observability only; capture ignores it.
  assign w_unused_op = ^r_op_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_op_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_accept};
      r_op_pipe[2] <= r_op_pipe[1];
      if (w_accept) r_op_pipe[1] <= alu_control;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= c_bus;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ac  <= '0;
      r_z   <= 1'b1;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_ac <= c_bus;
        r_z  <= (c_bus == 32'd0);
      end
      if (alu_enable && !issue_ready) r_ovf <= 1'b1;
    end
  end

  assign count        = r_count;
  assign out_valid    = (r_count != 3'd0);
  assign out_data     = out_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign ac           = r_ac;
  assign z_flag       = r_z;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed vector table, reset corner cases, then randomized traffic against a
// queue-based model of the result buffer.
module tb_alu_result_buffer;
  logic        clk, rst, alu_enable, out_ready;
  logic [3:0]  alu_control;
  logic [31:0] c_bus;
  logic        issue_ready, z_flag, out_valid, overflow_err;
  logic [31:0] ac, out_data;
  logic [2:0]  count;

  int n_chk = 0;
  int n_err = 0;

  alu_result_buffer dut (
    .clk(clk), .rst(rst), .alu_enable(alu_enable), .alu_control(alu_control),
    .c_bus(c_bus), .issue_ready(issue_ready), .ac(ac), .z_flag(z_flag),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  ctrl;
    logic [31:0] cbus;
    logic        ordy;
    logic [2:0]  cnt;
    logic [31:0] ac;
    logic        z, ovf, ov;
    logic [31:0] od;
    logic        rdy;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic en, logic [3:0] ctrl, logic [31:0] cbus, logic ordy,
                              logic [2:0] cnt, logic [31:0] a, logic z, logic ovf,
                              logic ov, logic [31:0] od, logic rdy);
    vec_t v;
    v.en = en; v.ctrl = ctrl; v.cbus = cbus; v.ordy = ordy; v.cnt = cnt; v.ac = a;
    v.z = z; v.ovf = ovf; v.ov = ov; v.od = od; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending captures keyed by the edge they complete on.
  int          m_inflight[$];
  logic [31:0] m_fifo[$];
  int          m_edge;
  logic [31:0] m_ac;
  logic        m_z, m_ovf, m_rdy;

  function automatic void model_reset();
    m_inflight.delete();
    m_fifo.delete();
    m_edge = 0;
    m_ac = 0; m_z = 1'b1; m_ovf = 1'b0;
  endfunction

  // Called with inputs stable just before an edge; advances the model over that edge.
  function automatic void model_edge(logic en, logic ordy, logic [31:0] cb);
    bit pop, cap;
    pop   = (m_fifo.size() != 0) && ordy;
    m_rdy = (m_fifo.size() + m_inflight.size() - (pop ? 1 : 0)) < 4;
    cap   = (m_inflight.size() != 0) && (m_inflight[0] == m_edge);
    if (pop) void'(m_fifo.pop_front());
    if (cap) begin
      void'(m_inflight.pop_front());
      m_fifo.push_back(cb);
      m_ac = cb;
      m_z  = (cb == 32'd0);
    end
    if (en) begin
      if (m_rdy) m_inflight.push_back(m_edge + 2);
      else       m_ovf = 1'b1;
    end
    m_edge++;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, ".count"}, {29'd0, count}, 32'd0);
    chk({tag, ".ac"}, ac, 32'd0);
    chk({tag, ".z"}, {31'd0, z_flag}, 32'd1);
    chk({tag, ".ovf"}, {31'd0, overflow_err}, 32'd0);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".data"}, out_data, 32'd0);
    chk({tag, ".ready"}, {31'd0, issue_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; alu_enable = 0; alu_control = 0; c_bus = 0; out_ready = 0;

    //            en ctrl  cbus          ordy cnt ac            z  ovf ov od            rdy
    tbl[0]  = mk(1, 4'h2, 32'h0,        0,   0, 32'h0,        1, 0,  0, 32'h0,        1);
    tbl[1]  = mk(0, 4'h0, 32'h7,        0,   0, 32'h0,        1, 0,  0, 32'h0,        1);
    tbl[2]  = mk(0, 4'h0, 32'h7,        0,   1, 32'h7,        0, 0,  1, 32'h7,        1);
    tbl[3]  = mk(0, 4'h0, 32'h0,        1,   0, 32'h7,        0, 0,  0, 32'h0,        1);
    tbl[4]  = mk(1, 4'h2, 32'hdead,     0,   0, 32'h7,        0, 0,  0, 32'h0,        1);
    tbl[5]  = mk(1, 4'h3, 32'hdead,     0,   0, 32'h7,        0, 0,  0, 32'h0,        1);
    tbl[6]  = mk(1, 4'h4, 32'h1,        0,   1, 32'h1,        0, 0,  1, 32'h1,        1);
    tbl[7]  = mk(1, 4'h5, 32'h2,        0,   2, 32'h2,        0, 0,  1, 32'h1,        0);
    tbl[8]  = mk(1, 4'h6, 32'h3,        0,   3, 32'h3,        0, 1,  1, 32'h1,        0);
    tbl[9]  = mk(0, 4'h0, 32'h4,        0,   4, 32'h4,        0, 1,  1, 32'h1,        0);
    tbl[10] = mk(0, 4'h0, 32'h0,        1,   3, 32'h4,        0, 1,  1, 32'h2,        1);
    tbl[11] = mk(0, 4'h0, 32'h0,        1,   2, 32'h4,        0, 1,  1, 32'h3,        1);
    tbl[12] = mk(0, 4'h0, 32'h0,        1,   1, 32'h4,        0, 1,  1, 32'h4,        1);
    tbl[13] = mk(0, 4'h0, 32'h0,        1,   0, 32'h4,        0, 1,  0, 32'h0,        1);
    tbl[14] = mk(1, 4'h2, 32'h0,        0,   0, 32'h4,        0, 1,  0, 32'h0,        1);
    tbl[15] = mk(1, 4'h2, 32'h0,        0,   0, 32'h4,        0, 1,  0, 32'h0,        1);
    tbl[16] = mk(1, 4'h2, 32'h11,       0,   1, 32'h11,       0, 1,  1, 32'h11,       1);
    tbl[17] = mk(0, 4'h0, 32'h22,       0,   2, 32'h22,       0, 1,  1, 32'h11,       1);
    tbl[18] = mk(0, 4'h0, 32'h33,       1,   2, 32'h33,       0, 1,  1, 32'h22,       1);
    tbl[19] = mk(0, 4'h0, 32'h0,        1,   1, 32'h33,       0, 1,  1, 32'h33,       1);
    tbl[20] = mk(1, 4'h9, 32'h5,        0,   1, 32'h33,       0, 1,  1, 32'h33,       1);
    tbl[21] = mk(0, 4'h0, 32'h5,        0,   1, 32'h33,       0, 1,  1, 32'h33,       1);
    tbl[22] = mk(0, 4'h0, 32'h0,        0,   2, 32'h0,        1, 1,  1, 32'h33,       1);
    tbl[23] = mk(0, 4'h0, 32'h0,        1,   1, 32'h0,        1, 1,  1, 32'h0,        1);
    tbl[24] = mk(0, 4'h0, 32'h0,        1,   0, 32'h0,        1, 1,  0, 32'h0,        1);

    #2 chk_reset_state("rst_hold");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      alu_enable = tbl[i].en; alu_control = tbl[i].ctrl;
      c_bus = tbl[i].cbus; out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.count", i), {29'd0, count}, {29'd0, tbl[i].cnt});
      chk($sformatf("vec%0d.ac", i), ac, tbl[i].ac);
      chk($sformatf("vec%0d.z", i), {31'd0, z_flag}, {31'd0, tbl[i].z});
      chk($sformatf("vec%0d.ovf", i), {31'd0, overflow_err}, {31'd0, tbl[i].ovf});
      chk($sformatf("vec%0d.valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("vec%0d.data", i), out_data, tbl[i].od);
      chk($sformatf("vec%0d.ready", i), {31'd0, issue_ready}, {31'd0, tbl[i].rdy});
    end

    // Reset arriving while one result is buffered and another is one edge from capture.
    out_ready = 0; alu_enable = 1; alu_control = 4'h2; c_bus = 32'h0;
    @(posedge clk); #1;
    c_bus = 32'h0;
    @(posedge clk); #1;
    alu_enable = 0; c_bus = 32'h55;
    @(posedge clk); #1;
    chk("mid.pre_count", {29'd0, count}, 32'd1);
    chk("mid.pre_ac", ac, 32'h55);
    c_bus = 32'h66;
    rst = 1'b1;
    #1 chk_reset_state("mid.async");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("mid.after1");
    @(posedge clk); #1;
    chk_reset_state("mid.after2");

    // Randomized traffic; the first edge after reset release carries an issue.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      alu_enable  = (n == 0) ? 1'b1 : ($urandom_range(0, 9) < 6);
      alu_control = 4'($urandom_range(0, 15));
      c_bus       = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      out_ready   = ($urandom_range(0, 9) < 4);
      #1;
      model_edge(alu_enable, out_ready, c_bus);
      chk("rnd.ready", {31'd0, issue_ready}, {31'd0, m_rdy});
      @(posedge clk); #1;
      chk("rnd.count", {29'd0, count}, m_fifo.size());
      chk("rnd.ac", ac, m_ac);
      chk("rnd.z", {31'd0, z_flag}, {31'd0, m_z});
      chk("rnd.ovf", {31'd0, overflow_err}, {31'd0, m_ovf});
      chk("rnd.valid", {31'd0, out_valid}, (m_fifo.size() != 0) ? 32'd1 : 32'd0);
      chk("rnd.data", out_data, (m_fifo.size() != 0) ? m_fifo[0] : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
